resp_misr: RTL
==============

# resp_misr

Response compactor that sits directly downstream of the `circuito12` serial FSM and consumes its `outp`/`overflw` pair every clock. It compacts a run of N responses into a WIDTH-bit multiple-input signature register (MISR) and compares the result against an expected signature. The result is a single pass/fail verdict for built-in self-test of the circuit under test.

## Interface
- `WIDTH`, 16: signature width in bits (≥ 4).
- `POLY`, 16'h002D: feedback mask for x^16+x^5+x^3+x^2+1; the x^WIDTH term is implicit.
- `SEED`, 16'h0000: signature value loaded at run start.
- `CNT_W`, 10: width of the cycle counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1: one-cycle pulse that begins a compaction run.
- `num_cycles`  in  CNT_W: number of response cycles to compact; sampled when `start` is accepted.
- `outp`  in  1: CUT response bit, injected into signature bit 0.
- `overflw`  in  1: CUT overflow bit, injected into signature bit 1.
- `exp_sig`  in  WIDTH: golden signature; sampled in the cycle the run completes.
- `busy`  out  1: high while in RUN.
- `done`  out  1: high while in DONE.
- `pass`  out  1: valid while `done` = 1; 1 when `signature` equals `exp_sig`.
- `signature`  out  WIDTH: current MISR contents.

## Operation
- FSM states: IDLE, RUN, DONE (2-bit encoding).
- Reset (`rst` = 0) forces, immediately and asynchronously:
  - state = IDLE;
  - `signature` = SEED;
  - counter = 0;
  - `busy` = 0, `done` = 0, `pass` = 0.
- IDLE with `start` = 1:
  - `signature` ← SEED, counter ← `num_cycles`.
  - If `num_cycles` = 0: go to DONE; `pass` ← (SEED == `exp_sig`).
  - Otherwise: go to RUN.
- RUN, every cycle:
  - `signature` ← ({sig[W-2:0],0} ^ (sig[W-1] ? POLY : 0)) ^ {0…0, `overflw`, `outp`}.
  - Counter decrements by 1.
  - When the counter is 1 (last compaction), go to DONE. In the same edge, register `pass` ← (new signature == `exp_sig`).
- DONE: `signature`, `pass` and `done` hold.
  - `start` = 1 begins a new run exactly as from IDLE (`done` drops on that edge).
  - There is no automatic return to IDLE.
- `start` while in RUN is ignored; the run continues and the counter is not reloaded.
- `outp`/`overflw` are ignored outside RUN.
- Counter arithmetic: unsigned, CNT_W bits, no wrap (it never decrements below 1 in RUN). The maximum run is 2^CNT_W − 1 cycles.
- Reset mid-run aborts the run: no `done` pulse, and `signature` = SEED.

## Timing
- `start` is sampled at rising edge t0.
- The first response is compacted at edge t0+1. This is the edge after `start`, so the CUT's first vector must be valid at t0+1.
- With N = `num_cycles` ≥ 1:
  - responses are compacted at edges t0+1 … t0+N;
  - `busy` = 1 from t0 to t0+N;
  - `done` and `pass` rise after edge t0+N.
- With N = 0: `done` rises after t0, and `busy` never asserts.
- The CUT bench changes inputs on the falling edge, so the inputs are stable at every rising edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold `rst` = 0 with random inputs → `signature` = 0x0000, and `busy`/`done`/`pass` = 0. Assert `rst` asynchronously mid-cycle → outputs clear before the next edge.
- Single cycle: SEED = 0, `num_cycles` = 1, (`outp`,`overflw`) = (1,0), `exp_sig` = 0x0001 → `signature` = 0x0001, `done` = 1, `pass` = 1, `busy` high for 1 cycle.
- Two cycles: responses (1,0) then (1,1), `exp_sig` = 0x0001 → `signature` = 0x0001, `pass` = 1. Repeat with `exp_sig` = 0x0002 → `pass` = 0.
- Feedback: SEED = 0x8000, `num_cycles` = 1, response (0,0) → `signature` = 0x002D.
- Zero-length run: `num_cycles` = 0, `exp_sig` = 0 → `done` in the next cycle, `pass` = 1, `busy` never 1.
- Full b01.vec sequence:
  - `num_cycles` = 10, driven from the 10 stored vectors; a second `start` pulse at cycle 5 is ignored.
  - After completion, `start` again with the same vectors → identical signature, `pass` = 1 against the golden model.

Source files
------------

// File: rtl/resp_misr.sv
// rtl/resp_misr.sv - MISR response compactor with pass/fail verdict for serial-FSM BIST
module resp_misr #(
  parameter int                 WIDTH = 16,
  parameter logic [WIDTH-1:0]   POLY  = 16'h002D,
  parameter logic [WIDTH-1:0]   SEED  = 16'h0000,
  parameter int                 CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic             outp,
  input  logic             overflw,
  input  logic [WIDTH-1:0] exp_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sig_q, sig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pass_q, pass_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sig_next;

  // Shift with polynomial feedback, then fold in the two CUT response bits.
  always_comb begin
    sig_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0)
             ^ {{(WIDTH-2){1'b0}}, overflw, outp};
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    case (state_q)
      RUN: begin
        sig_d = sig_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          pass_d  = (sig_next == exp_sig);
        end
      end
      default: begin
        // IDLE and DONE both accept a new run; DONE otherwise holds its verdict.
        if (start) begin
          sig_d  = SEED;
          cnt_d  = num_cycles;
          pass_d = 1'b0;
          if (num_cycles == '0) begin
            state_d = DONE;
            pass_d  = (SEED == exp_sig);
          end else begin
            state_d = RUN;
          end
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule
